// File: rtl/power_of_n_scheduler.sv
// Round-robin share of one power-of-eight datapath; accept-to-response PIPE_LAT+2 cycles, 1 op/cycle.
// Backpressure via o_req_ready once MAX_INFLIGHT ops are outstanding; responses cannot be stalled.
module power_of_n_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int PIPE_LAT     = 3,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                              i_clock,
  input  logic                              i_reset_async_n,
  input  logic [NUM_REQ-1:0]                i_req_valid,
  input  logic [4*NUM_REQ-1:0]              i_req_value,
  output logic [NUM_REQ-1:0]                o_req_ready,
  output logic [3:0]                        o_dp_value,
  output logic                              o_dp_status,
  input  logic [60:0]                       i_dp_value,
  input  logic                              i_dp_status,
  output logic [NUM_REQ-1:0]                o_rsp_valid,
  output logic [60:0]                       o_rsp_value,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] o_inflight,
  output logic                              o_error
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_INFLIGHT + 1);

  logic [IDW-1:0]               ptr_q, ptr_d;
  logic [3:0]                   dp_value_q, dp_value_d;
  logic                         dp_status_q, dp_status_d;
  logic [IDW-1:0]               dp_id_q, dp_id_d;
  logic [PIPE_LAT-1:0]          tag_vld_q, tag_vld_d;
  logic [PIPE_LAT-1:0][IDW-1:0] tag_id_q, tag_id_d;
  logic [NUM_REQ-1:0]           rsp_valid_q, rsp_valid_d;
  logic [60:0]                  rsp_value_q, rsp_value_d;
  logic [CW-1:0]                inflight_q, inflight_d;
  logic                         error_q, error_d;

  logic           tail_vld;
  logic [IDW-1:0] tail_id;
  logic           retire;
  logic           can_issue;
  logic           grant_vld;
  logic [IDW-1:0] grant_id;
  logic           accept;
  logic [3:0]     operand;
  int             idx;

  assign tail_vld = tag_vld_q[PIPE_LAT-1];
  assign tail_id  = tag_id_q[PIPE_LAT-1];
  // The departing tag frees its slot even if the datapath failed to strobe with it.
  assign retire    = tail_vld;
  assign can_issue = (inflight_q < CW'(MAX_INFLIGHT)) | retire;

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!grant_vld && i_req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_id  = IDW'(idx);
      end
    end
  end

  assign accept      = can_issue & grant_vld;
  assign operand     = i_req_value[4*int'(grant_id) +: 4];
  assign o_req_ready = accept ? (NUM_REQ'(1) << grant_id) : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
    end

    dp_status_d = accept;
    dp_value_d  = accept ? operand : dp_value_q;
    dp_id_d     = accept ? grant_id : dp_id_q;

    tag_vld_d    = tag_vld_q;
    tag_id_d     = tag_id_q;
    tag_vld_d[0] = dp_status_q;
    tag_id_d[0]  = dp_id_q;
    for (int k = 1; k < PIPE_LAT; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
    end

    // Results arriving without a tag are dropped; only the error flag records them.
    rsp_valid_d = '0;
    rsp_value_d = rsp_value_q;
    if (i_dp_status && tail_vld) begin
      rsp_valid_d = NUM_REQ'(1) << tail_id;
      rsp_value_d = i_dp_value;
    end

    inflight_d = inflight_q + CW'(accept) - CW'(retire);
    error_d    = error_q | (i_dp_status != tail_vld);
  end

  always_ff @(posedge i_clock or negedge i_reset_async_n) begin
    if (!i_reset_async_n) begin
      ptr_q       <= '0;
      dp_value_q  <= '0;
      dp_status_q <= 1'b0;
      dp_id_q     <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      rsp_valid_q <= '0;
      rsp_value_q <= '0;
      inflight_q  <= '0;
      error_q     <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      dp_value_q  <= dp_value_d;
      dp_status_q <= dp_status_d;
      dp_id_q     <= dp_id_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_value_q <= rsp_value_d;
      inflight_q  <= inflight_d;
      error_q     <= error_d;
    end
  end

  assign o_dp_value  = dp_value_q;
  assign o_dp_status = dp_status_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_value = rsp_value_q;
  assign o_inflight  = inflight_q;
  assign o_error     = error_q;
endmodule

// File: tb/tb_power_of_n_scheduler.sv
// Bench for power_of_n_scheduler: default instance against a cycle-level reference model,
// plus a MAX_INFLIGHT=2 instance for the outstanding-cap sequence.
module tb_power_of_n_scheduler;
  localparam int NC = 2048;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid, req_ready, dp_value, rsp_valid;
  logic [15:0] req_value;
  logic        dp_status, dpi_status, error, force_st;
  logic [60:0] dpi_value, rsp_value;
  logic [2:0]  inflight;

  logic [3:0]  c_req_valid, c_req_ready, c_dp_value, c_rsp_valid;
  logic [15:0] c_req_value;
  logic        c_dp_status, c_dpi_status, c_error;
  logic [60:0] c_dpi_value, c_rsp_value;
  logic [1:0]  c_inflight;

  always #5 clk = ~clk;

  power_of_n_scheduler u_dut (
    .i_clock(clk), .i_reset_async_n(rst_n),
    .i_req_valid(req_valid), .i_req_value(req_value), .o_req_ready(req_ready),
    .o_dp_value(dp_value), .o_dp_status(dp_status),
    .i_dp_value(dpi_value), .i_dp_status(dpi_status),
    .o_rsp_valid(rsp_valid), .o_rsp_value(rsp_value),
    .o_inflight(inflight), .o_error(error)
  );

  power_of_n_scheduler #(.MAX_INFLIGHT(2)) u_cap (
    .i_clock(clk), .i_reset_async_n(rst_n),
    .i_req_valid(c_req_valid), .i_req_value(c_req_value), .o_req_ready(c_req_ready),
    .o_dp_value(c_dp_value), .o_dp_status(c_dp_status),
    .i_dp_value(c_dpi_value), .i_dp_status(c_dpi_status),
    .o_rsp_valid(c_rsp_valid), .o_rsp_value(c_rsp_value),
    .o_inflight(c_inflight), .o_error(c_error)
  );

  function automatic logic [60:0] pow8(input logic [3:0] x);
    longint p = 1;
    for (int i = 0; i < 8; i++) p = p * longint'(x);
    return 61'(p);
  endfunction

  // Three-stage datapath models sharing the scheduler reset.
  logic [2:0]  st_q, c_st_q;
  logic [60:0] val_q [3];
  logic [60:0] c_val_q [3];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= '0;
      c_st_q <= '0;
      for (int i = 0; i < 3; i++) begin
        val_q[i]   <= '0;
        c_val_q[i] <= '0;
      end
    end else begin
      st_q       <= {st_q[1:0], dp_status};
      c_st_q     <= {c_st_q[1:0], c_dp_status};
      val_q[0]   <= pow8(dp_value);
      c_val_q[0] <= pow8(c_dp_value);
      for (int i = 1; i < 3; i++) begin
        val_q[i]   <= val_q[i-1];
        c_val_q[i] <= c_val_q[i-1];
      end
    end
  end
  assign dpi_status   = st_q[2] | force_st;
  assign dpi_value    = force_st ? 61'h1ABCD : val_q[2];
  assign c_dpi_status = c_st_q[2];
  assign c_dpi_value  = c_val_q[2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  rdy;
    logic        dps;
    logic [3:0]  dpv;
    logic [3:0]  rv;
    logic [60:0] rval;
    logic [2:0]  infl;
    logic        err;
    logic [3:0]  c_rdy;
    logic [1:0]  c_infl;
  } obs_t;

  typedef struct {
    logic [3:0]  op;
    logic [60:0] res;
  } vec_t;

  // Reference model: accept history indexed by cycle number; everything else derived from it.
  logic        acc_vld [NC];
  int          acc_id  [NC];
  logic [3:0]  acc_val [NC];
  int          t = 0;
  int          m_base = 0;
  int          m_ptr = 0;
  logic [3:0]  m_last_dp = '0;
  logic [60:0] m_last_rsp = '0;
  logic        m_err = 1'b0;

  function automatic logic acc_ok(input int c);
    if (c < 0 || c < m_base || c >= NC) return 1'b0;
    return acc_vld[c];
  endfunction

  task automatic model_reset();
    m_base     = t;
    m_ptr      = 0;
    m_last_dp  = '0;
    m_last_rsp = '0;
    m_err      = 1'b0;
  endtask

  task automatic step(input logic [3:0] v, input logic [15:0] vals, input logic frc,
                      input logic [3:0] cv, output obs_t o);
    int         infl;
    int         g;
    logic       ret;
    logic       can;
    logic [3:0] erdy;
    logic [3:0] erv;
    @(negedge clk);
    req_valid   = v;
    req_value   = vals;
    force_st    = frc;
    c_req_valid = cv;
    #1;
    o.rdy = req_ready; o.dps = dp_status; o.dpv = dp_value; o.rv = rsp_valid;
    o.rval = rsp_value; o.infl = inflight; o.err = error;
    o.c_rdy = c_req_ready; o.c_infl = c_inflight;

    // Outstanding = accepts in the last four cycles; the oldest of them retires this cycle.
    infl = 0;
    for (int c = t - 4; c < t; c++) if (acc_ok(c)) infl++;
    ret = acc_ok(t - 4);
    can = (infl < 4) || ret;
    g = -1;
    if (can) begin
      for (int k = 0; k < 4; k++) begin
        if (g < 0 && v[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      end
    end
    erdy = (g >= 0) ? 4'(1 << g) : 4'd0;
    erv  = 4'd0;
    if (acc_ok(t - 5)) begin
      erv        = 4'(1 << acc_id[t-5]);
      m_last_rsp = pow8(acc_val[t-5]);
    end
    chk("ready", 64'(req_ready), 64'(erdy));
    chk("inflight", 64'(inflight), 64'(infl));
    chk("dp_status", 64'(dp_status), 64'(acc_ok(t - 1)));
    chk("dp_value", 64'(dp_value), 64'(m_last_dp));
    chk("rsp_valid", 64'(rsp_valid), 64'(erv));
    chk("rsp_value", 64'(rsp_value), 64'(m_last_rsp));
    chk("error", 64'(error), 64'(m_err));

    acc_vld[t] = (g >= 0);
    acc_id[t]  = g;
    acc_val[t] = (g >= 0) ? vals[4*g +: 4] : 4'd0;
    if (g >= 0) begin
      m_ptr     = (g + 1) % 4;
      m_last_dp = vals[4*g +: 4];
    end
    if (frc && !ret) m_err = 1'b1;
    t++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    obs_t        o;
    vec_t        tbl [4];
    logic [11:0] cap_rdy_pat;
    tbl[0] = '{op: 4'd0,  res: 61'd0};
    tbl[1] = '{op: 4'd1,  res: 61'd1};
    tbl[2] = '{op: 4'd3,  res: 61'd6561};
    tbl[3] = '{op: 4'd15, res: 61'd2562890625};
    cap_rdy_pat = 12'b0011_0011_0011;

    req_valid = '0; req_value = '0; force_st = 1'b0;
    c_req_valid = '0; c_req_value = 16'h0002;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_dp_status", 64'(dp_status), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_value", 64'(rsp_value), 64'(0));
    chk("rst_inflight", 64'(inflight), 64'(0));
    chk("rst_error", 64'(error), 64'(0));
    rst_n = 1'b1;
    model_reset();
    repeat (2) step(4'h0, 16'h0, 1'b0, 4'h0, o);

    // Fairness: all requesters valid, grants rotate from pointer 0.
    for (int i = 0; i < 13; i++) begin
      step((i < 8) ? 4'hF : 4'h0, 16'($urandom), 1'b0, 4'h0, o);
      if (i < 8) chk("t2_grant", 64'(o.rdy), 64'(4'b0001 << (i % 4)));
      if (i >= 5) chk("t2_rsp_tag", 64'(o.rv), 64'(4'b0001 << ((i - 5) % 4)));
    end

    // Single op from requester 1: operand 2 returns 256 five cycles after accept.
    step(4'b0010, 16'h0020, 1'b0, 4'h0, o);
    chk("t1_ready", 64'(o.rdy), 64'(4'b0010));
    for (int k = 1; k <= 5; k++) begin
      step(4'h0, 16'h0, 1'b0, 4'h0, o);
      if (k == 1) chk("t1_dp_status", 64'(o.dps), 64'(1));
      if (k == 1) chk("t1_dp_value", 64'(o.dpv), 64'(2));
      if (k < 5) chk("t1_no_rsp", 64'(o.rv), 64'(0));
      if (k == 5) chk("t1_rsp_valid", 64'(o.rv), 64'(4'b0010));
      if (k == 5) chk("t1_rsp_value", 64'(o.rval), 64'(256));
    end

    // Value table issued back-to-back from requester 0.
    for (int i = 0; i < 9; i++) begin
      step((i < 4) ? 4'b0001 : 4'b0000, (i < 4) ? {12'h0, tbl[i].op} : 16'h0, 1'b0, 4'h0, o);
      if (i < 4) chk("t3_ready", 64'(o.rdy), 64'(4'b0001));
      if (i >= 5) chk("t3_rsp_valid", 64'(o.rv), 64'(4'b0001));
      if (i >= 5) chk("t3_rsp_value", 64'(o.rval), 64'(tbl[i-5].res));
    end

    // Outstanding cap of 2 on the second instance with requester 0 held valid.
    for (int i = 0; i < 18; i++) begin
      step(4'h0, 16'h0, 1'b0, (i < 12) ? 4'b0001 : 4'b0000, o);
      if (i < 12) chk("t4_cap_ready", 64'(o.c_rdy), 64'({3'b000, cap_rdy_pat[i]}));
      if (i < 12) chk("t4_cap_inflight", 64'(o.c_infl), 64'((i == 0) ? 0 : (i == 1) ? 1 : 2));
    end
    chk("t4_cap_drained", 64'(o.c_infl), 64'(0));
    chk("t4_cap_error", 64'(c_error), 64'(0));

    for (int i = 0; i < 300; i++) step(4'($urandom), 16'($urandom), 1'b0, 4'h0, o);
    repeat (6) step(4'h0, 16'h0, 1'b0, 4'h0, o);

    // Spurious result strobe with an empty tag pipe.
    step(4'h0, 16'h0, 1'b1, 4'h0, o);
    for (int i = 0; i < 3; i++) begin
      step(4'h0, 16'h0, 1'b0, 4'h0, o);
      chk("t5_error", 64'(o.err), 64'(1));
      chk("t5_no_rsp", 64'(o.rv), 64'(0));
      chk("t5_inflight", 64'(o.infl), 64'(0));
    end

    // Reset with three operations outstanding.
    repeat (3) step(4'b0001, 16'h0005, 1'b0, 4'h0, o);
    step(4'h0, 16'h0, 1'b0, 4'h0, o);
    chk("t6_pre_inflight", 64'(o.infl), 64'(3));
    rst_n = 1'b0;
    #1;
    chk("t6_ready", 64'(req_ready), 64'(0));
    chk("t6_dp_status", 64'(dp_status), 64'(0));
    chk("t6_dp_value", 64'(dp_value), 64'(0));
    chk("t6_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("t6_rsp_value", 64'(rsp_value), 64'(0));
    chk("t6_inflight", 64'(inflight), 64'(0));
    chk("t6_error", 64'(error), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      step(4'h0, 16'h0, 1'b0, 4'h0, o);
      chk("t6_no_stale_rsp", 64'(o.rv), 64'(0));
    end
    step(4'b0100, 16'h0300, 1'b0, 4'h0, o);
    chk("t6_ready_after", 64'(o.rdy), 64'(4'b0100));
    repeat (5) step(4'h0, 16'h0, 1'b0, 4'h0, o);
    chk("t6_rsp_valid_after", 64'(o.rv), 64'(4'b0100));
    chk("t6_rsp_value_after", 64'(o.rval), 64'(6561));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
